// File: rtl/uart_rx.sv
// uart_rx: 8N1-style serial receiver.
//
// Oversamples the asynchronous rx line on the system clock and samples each
// bit at its centre with an internal bit-period counter. A frame is one start
// bit, DATA_BITS data bits (LSB first) and one stop bit. Good frames update
// data_out with a one-cycle data_valid pulse; a low stop bit gives a one-cycle
// frame_err pulse and the receiver then waits for the line to go high again.
//
// Parameters:
//   CLKS_PER_BIT  clocks per serial bit (>= 4)
//   DATA_BITS     data bits per frame (5..9)
//
// Ports:
//   clk         in   system clock, rising edge active
//   rst         in   asynchronous reset, active low
//   rx          in   serial line, asynchronous, idles high
//   data_out    out  last good received word, held until the next good frame
//   data_valid  out  one-cycle pulse when data_out has just been updated
//   frame_err   out  one-cycle pulse when the stop bit was sampled low
//   busy        out  high whenever the receiver is not idle

module uart_rx #(
  parameter int CLKS_PER_BIT = 5210,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int CW   = $clog2(CLKS_PER_BIT);
  // idx must be able to hold DATA_BITS after the last increment
  localparam int IW   = $clog2(DATA_BITS + 1);

  localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_BREAK = 3'd4;

  logic [2:0]           state;
  logic [CW-1:0]        cnt;
  logic [IW-1:0]        idx;
  logic [DATA_BITS-1:0] sh;
  logic                 rx_meta;
  logic                 rx_s;

  // Two-flop synchronizer. Both flops reset high so that an idle line does
  // not look like a start bit coming out of reset; a line that is really low
  // still propagates through two clocks later and is taken as a start bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // Receive state machine and datapath.
  // START counts half a bit to land on the start-bit centre; from there every
  // full bit period lands on the centre of the next bit. The counter is
  // always cleared at its terminal value, so there is no wrap and no
  // resynchronisation to line edges once a frame has been accepted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      idx        <= '0;
      sh         <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!rx_s) begin
            state <= S_START;
            cnt   <= '0;
          end
        end
        S_START: begin
          if (cnt == HALF_LAST) begin
            cnt <= '0;
            if (!rx_s) begin
              state <= S_DATA;
              idx   <= '0;
            end else begin
              // line went back high before the centre: a glitch, not a frame
              state <= S_IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (cnt == CNT_LAST) begin
            // LSB arrives first, so new bits enter at the top and shift down
            sh  <= {rx_s, sh[DATA_BITS-1:1]};
            cnt <= '0;
            idx <= idx + 1'b1;
            if (idx == IDX_LAST) begin
              state <= S_STOP;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (cnt == CNT_LAST) begin
            cnt <= '0;
            if (rx_s) begin
              data_out   <= sh;
              data_valid <= 1'b1;
              state      <= S_IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= S_BREAK;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_BREAK: begin
          // a held-low line reports one error only, then waits for idle
          if (rx_s) begin
            state <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy = (state != S_IDLE);

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver for the full-duplex UART. It runs on the system clock, oversamples the asynchronous `rx` line, and samples each bit at its centre using an internal bit-period counter. Each frame is 8N1 by default: start bit, `DATA_BITS` data bits LSB first, one stop bit. It delivers each good byte with a one-cycle valid pulse and flags bad stop bits. The default bit period of 5210 clocks equals one full period of the team's baud clock, which counts 2605 clocks per half-period.

## Interface
- `CLKS_PER_BIT`, default 5210: clocks per bit; must be ≥ 4. `HALF = CLKS_PER_BIT/2`, integer division.
- `DATA_BITS`, default 8: data bits per frame; range 5–9.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  reset; one clock; reset is asynchronous and active-low.
- `rx`  in  1  serial line, asynchronous to `clk`; idles high.
- `data_out`  out  DATA_BITS  last good received word; holds until the next good frame.
- `data_valid`  out  1  one-cycle pulse: `data_out` was just updated.
- `frame_err`  out  1  one-cycle pulse: stop bit sampled low.
- `busy`  out  1  high in every state except IDLE.

## Operation
- **Synchronizer**
  - 2-flop synchronizer on `rx`; both flops reset to 1.
  - All decisions use the synchronized bit `rx_s` only.
- **Datapath registers**
  - Counter `cnt`, width `$clog2(CLKS_PER_BIT)`.
  - Bit index `idx`.
  - Shift register `sh`: shifts right, new bit enters at the MSB, so LSB-first data lands in the correct positions.
- **States:** IDLE, START, DATA, STOP, BREAK.
- **IDLE**
  - `rx_s==0` → START, `cnt<=0`.
- **START**
  - `cnt` increments each clock.
  - At `cnt==HALF-1`: if `rx_s==0` → DATA with `cnt<=0`, `idx<=0`.
  - Otherwise the start was a glitch → IDLE; no pulse.
- **DATA**
  - `cnt` increments each clock.
  - At `cnt==CLKS_PER_BIT-1`: `sh <= {rx_s, sh[DATA_BITS-1:1]}`, `cnt<=0`, `idx<=idx+1`.
  - After the sample with `idx==DATA_BITS-1` → STOP.
- **STOP**
  - At `cnt==CLKS_PER_BIT-1`:
    - `rx_s==1`: `data_out<=sh`, `data_valid<=1` for one cycle → IDLE.
    - `rx_s==0`: `frame_err<=1` for one cycle; `data_out` unchanged → BREAK.
- **BREAK**
  - Wait for `rx_s==1` → IDLE.
  - A held-low line therefore produces exactly one `frame_err` and no further frames.
- **Invariants**
  - `data_valid` and `frame_err` are never high in the same cycle.
  - No counter wraps: `cnt` is always cleared at its terminal value.
  - `rx` activity during DATA or STOP does not alter the bit timing; there is no resynchronisation mid-frame.
- **Reset** (asynchronous; any state, including mid-frame)
  - State=IDLE; `cnt`, `idx`, `sh`, `data_out` = 0; `data_valid`=0, `frame_err`=0, `busy`=0; synchronizer flops=1.
  - The partial frame is discarded with no pulse.
  - After reset release, a line already low is treated as a start bit.

## Timing
- Let E0 be the first clock edge at which the synchronizer's first flop captures `rx` low.
- `rx_s` is low after E1. IDLE detects it at E2, and `busy` is high from E2.
- The start-bit centre check occurs at edge E2+HALF.
- Data bit k is sampled at edge E2+HALF+(k+1)·CLKS_PER_BIT.
- The stop bit is sampled at edge E2+HALF+(DATA_BITS+1)·CLKS_PER_BIT.
  - `data_valid` or `frame_err` is high for the single cycle following that edge.
  - `busy` falls on the same edge.
  - Defaults: edge E0+49497.
- Back-to-back frames: a start edge in the cycle after return to IDLE is accepted. Minimum idle between frames is 0 line-bit-times beyond the stop-bit remainder.
- Baud tolerance: sampling at centre ±1 clock; a receiver/transmitter mismatch of ±4 % is accepted at defaults.

## Test plan
- **Reset values:** assert `rst`=0 for 3 cycles with `rx`=1 → all outputs 0, `busy`=0. Release; hold `rx`=1 for 20000 cycles → no pulses.
- **Single byte:** send 0xA5 at 5210 clocks/bit, stop=1 → `data_valid` single pulse at E0+49497 with `data_out`=0xA5, `frame_err`=0.
- **Back-to-back frames:** send 0x00, 0xFF, 0x3C with no idle gap → exactly three `data_valid` pulses, values in order. The second pulse occurs exactly 10·5210 cycles after the first.
- **Glitch rejection:** drive `rx` low for 1000 cycles (less than HALF), then high → state returns to IDLE, `busy` pulse only, no `data_valid`/`frame_err`.
- **Framing error / break:** send 0x55 with stop bit=0, then hold the line low for 3 bit-times → one `frame_err` pulse, `data_out` keeps its prior value. After the line rises and a 0x12 frame is sent → `data_valid` with 0x12.
- **Reset mid-frame:** assert `rst` during data bit 4 of a frame → outputs cleared immediately, no pulse. The next full frame, 0x81, is received correctly.
